// File: rtl/ring_meter_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter:
// FSM state enum, gray/binary conversion and saturating accumulate.
package ring_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    MEAS  = 2'd2,
    DONE  = 2'd3
  } meter_state_t;

  // Widths up to 32 bits; upper zero bits leave both conversions unchanged.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Returns {saturated, sum} where sum is clamped to 2^w - 1.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) begin
      return {1'b1, lim[31:0]};
    end
    return {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/ring_freq_meter_if.sv
// Control/result bus of ring_freq_meter; the meter is the slave side.
interface ring_freq_meter_if #(
    parameter int NCH = 4,
    parameter int GW  = 16
);
    logic           i_start;
    logic           i_cont;
    logic [GW-1:0]  i_gate;
    logic [2:0]     i_ch_sel;
    logic [1:0]     i_byte_sel;
    logic           o_busy;
    logic           o_done;
    logic [NCH-1:0] o_ovf;
    logic [7:0]     o_data;

    modport master (
        output i_start, i_cont, i_gate, i_ch_sel, i_byte_sel,
        input  o_busy, o_done, o_ovf, o_data
    );

    modport slave (
        input  i_start, i_cont, i_gate, i_ch_sel, i_byte_sel,
        output o_busy, o_done, o_ovf, o_data
    );
endinterface

// File: rtl/ring_gray_cnt.sv
// Ring-domain free-running counter with registered gray output.
// RING_FREQ_METER_PRESCALE_EN adds a divide-by-16 prescaler ahead of the counter.
module ring_gray_cnt
    import ring_meter_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          i_ring_clk,
    output logic [CW-1:0] o_gray
);

    logic [CW-1:0] bin_q;
    logic [CW-1:0] bin_nxt;
    logic          tick;

`ifdef RING_FREQ_METER_PRESCALE_EN
    logic [3:0] pre_q;

    always_ff @(posedge i_ring_clk) begin
        pre_q <= pre_q + 4'd1;
    end

    assign tick = (pre_q == 4'hF);
`else
    assign tick = 1'b1;
`endif

    assign bin_nxt = bin_q + CW'(1);

    // NOTE: deliberately no reset -- the ring clock has no reset domain and the
    // measuring side only ever uses differences, so the starting value is irrelevant.
    always_ff @(posedge i_ring_clk) begin
        if (tick) begin
            bin_q  <= bin_nxt;
            o_gray <= CW'(bin2gray(32'(bin_nxt)));
        end
    end

endmodule

// File: rtl/ring_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: gated delta accumulation
// of synchronised gray counters. Optional RING_FREQ_METER_PRESCALE_EN in ring_gray_cnt.
module ring_freq_meter
    import ring_meter_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CW   = 8,
    parameter int AW   = 24,
    parameter int GW   = 16,
    parameter int SYNC = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NCH-1:0]     i_ring_clk,
    ring_freq_meter_if.slave   bus
);

    meter_state_t   state_q;
    meter_state_t   state_d;

    logic [CW-1:0]  cur      [NCH];
    logic [CW-1:0]  delta    [NCH];
    logic [32:0]    sum      [NCH];
    logic [CW-1:0]  prev_q   [NCH];
    logic [AW-1:0]  acc_q    [NCH];
    logic [AW-1:0]  result_q [NCH];
    logic [NCH-1:0] ovf_acc_q;
    logic [NCH-1:0] ovf_q;
    logic [GW-1:0]  gcnt_q;
    logic           done_q;
    logic [31:0]    res_pad  [8];
    logic [7:0]     data_d;
    logic [7:0]     data_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0] gray;
        logic [CW-1:0] sync_q [SYNC];

        ring_gray_cnt #(.CW(CW)) u_cnt (
            .i_ring_clk (i_ring_clk[c]),
            .o_gray     (gray)
        );

        // Gray coding guarantees at most one bit in flight across the domain boundary.
        always_ff @(posedge i_clk) begin
            sync_q[0] <= gray;
            for (int s = 1; s < SYNC; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end

        assign cur[c]   = CW'(gray2bin(32'(sync_q[SYNC-1])));
        assign delta[c] = cur[c] - prev_q[c];
        assign sum[c]   = sat_add(32'(acc_q[c]), 32'(delta[c]), AW);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_start) state_d = PRIME;
            PRIME:   state_d = MEAS;
            MEAS:    if (gcnt_q == '0) state_d = DONE;
            DONE:    state_d = bus.i_cont ? PRIME : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the result array is a handful of flops, not a RAM, so it takes the
    // reset like any other state; reads after reset must return zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gcnt_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= '0;
            ovf_acc_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                prev_q[c]   <= '0;
                acc_q[c]    <= '0;
                result_q[c] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                PRIME: begin
                    gcnt_q    <= (bus.i_gate == '0) ? '0 : bus.i_gate - GW'(1);
                    ovf_acc_q <= '0;
                    for (int c = 0; c < NCH; c++) begin
                        prev_q[c] <= cur[c];
                        acc_q[c]  <= '0;
                    end
                end
                MEAS: begin
                    if (gcnt_q != '0) gcnt_q <= gcnt_q - GW'(1);
                    for (int c = 0; c < NCH; c++) begin
                        prev_q[c] <= cur[c];
                        acc_q[c]  <= AW'(sum[c][31:0]);
                        if (sum[c][32]) ovf_acc_q[c] <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    ovf_q  <= ovf_acc_q;
                    for (int c = 0; c < NCH; c++) begin
                        result_q[c] <= acc_q[c];
                    end
                end
                default: ;
            endcase
        end
    end

    // Zero-padding to 8 channels x 32 bits makes out-of-range selects read 0x00.
    for (genvar c = 0; c < 8; c++) begin : g_pad
        if (c < NCH) begin : g_used
            assign res_pad[c] = 32'(result_q[c]);
        end else begin : g_empty
            assign res_pad[c] = '0;
        end
    end

    always_comb begin
        data_d = res_pad[bus.i_ch_sel][{bus.i_byte_sel, 3'b000} +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= 8'h00;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.o_busy = (state_q == PRIME) || (state_q == MEAS);
    assign bus.o_done = done_q;
    assign bus.o_ovf  = ovf_q;
    assign bus.o_data = data_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed bench for ring_freq_meter: a 24-bit DUT and an 8-bit (saturating)
// DUT run in lockstep on the same ring clocks and controls.
`timescale 1ns/100ps
module tb_ring_freq_meter;

    localparam int NCH = 4;
    localparam int GW  = 16;

    typedef struct {
        int ch;
        int bsel;
        int exp;
        int tol;
        int sexp;
        int stol;
    } rd_vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] ring_clk;
    int             ring_half [NCH] = '{2, 15, 25, 35};

    int   checks = 0;
    int   errors = 0;
    logic busy1;

    ring_freq_meter_if #(.NCH(NCH), .GW(GW)) bus ();
    ring_freq_meter_if #(.NCH(NCH), .GW(GW)) sbus ();

    assign sbus.i_start    = bus.i_start;
    assign sbus.i_cont     = bus.i_cont;
    assign sbus.i_gate     = bus.i_gate;
    assign sbus.i_ch_sel   = bus.i_ch_sel;
    assign sbus.i_byte_sel = bus.i_byte_sel;

    ring_freq_meter #(.NCH(NCH), .CW(8), .AW(24), .GW(GW), .SYNC(2)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ring_clk (ring_clk),
        .bus        (bus)
    );

    ring_freq_meter #(.NCH(NCH), .CW(8), .AW(8), .GW(GW), .SYNC(2)) dut_sat (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ring_clk (ring_clk),
        .bus        (sbus)
    );

    always #5 clk = ~clk;

    // Fractional start offsets keep ring edges off i_clk edges.
    for (genvar c = 0; c < NCH; c++) begin : g_ring
        logic rc = 1'b0;
        initial begin
            #(0.3 + 0.1 * c);
            forever #(ring_half[c]) rc = ~rc;
        end
        assign ring_clk[c] = rc;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int got, input int want, input int tol);
        checks++;
        if (got > want + tol || got < want - tol) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", name, got, want, tol);
        end
    endtask

    // Starts a window at a negedge; lat = edges from start sample to o_done, -1 on timeout.
    task automatic run_window(input int g, output int lat);
        lat = -1;
        bus.i_gate  = GW'(g);
        bus.i_start = 1'b1;
        for (int n = 1; n <= g + 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.i_start = 1'b0;
                busy1 = bus.o_busy;
            end
            if (bus.o_done) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic rd(input int ch, input int b, output int v, output int vs);
        bus.i_ch_sel   = 3'(ch);
        bus.i_byte_sel = 2'(b);
        @(negedge clk);
        v  = int'(bus.o_data);
        vs = int'(sbus.o_data);
    endtask

    initial begin
        rd_vec_t ss_vec [4];
        rd_vec_t mc_vec [11];
        int lat, v, vs, ndone, off_at;
        int dt [4];

        ss_vec = '{'{0, 0, 250, 1, 250, 1}, '{0, 1, 0, 0, 0, 0},
                   '{0, 2, 0, 0, 0, 0},     '{0, 3, 0, 0, 0, 0}};
        mc_vec = '{'{0, 0, 244, 1, 255, 0}, '{0, 1, 1, 0, 0, 0},
                   '{0, 2, 0, 0, 0, 0},     '{0, 3, 0, 0, 0, 0},
                   '{1, 0, 77, 1, 255, 0},  '{1, 1, 1, 0, 0, 0},
                   '{2, 0, 200, 1, 200, 1}, '{2, 1, 0, 0, 0, 0},
                   '{3, 0, 143, 1, 143, 1}, '{4, 0, 0, 0, 0, 0},
                   '{7, 1, 0, 0, 0, 0}};

        // NOTE: stimulus is driven with blocking assignments at the negedge,
        // half a cycle away from the edge where the DUT samples it.
        bus.i_start    = 1'b0;
        bus.i_cont     = 1'b0;
        bus.i_gate     = '0;
        bus.i_ch_sel   = '0;
        bus.i_byte_sel = '0;

        repeat (3) @(negedge clk);
        check("reset busy", int'(bus.o_busy), 0, 0);
        check("reset done", int'(bus.o_done), 0, 0);
        check("reset ovf", int'(bus.o_ovf), 0, 0);
        check("reset data", int'(bus.o_data), 0, 0);
        rst = 1'b0;

        bus.i_start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst beats start", int'(bus.o_busy), 0, 0);

        // Single shot: ch0 period 4 ns, G=100 -> 1000 ns / 4 ns = 250.
        run_window(100, lat);
        check("single latency", lat, 102, 0);
        check("single busy after start", int'(busy1), 1, 0);
        foreach (ss_vec[i]) begin
            rd(ss_vec[i].ch, ss_vec[i].bsel, v, vs);
            check($sformatf("single ch%0d b%0d", ss_vec[i].ch, ss_vec[i].bsel), v, ss_vec[i].exp, ss_vec[i].tol);
            check($sformatf("single8 ch%0d b%0d", ss_vec[i].ch, ss_vec[i].bsel), vs, ss_vec[i].sexp, ss_vec[i].stol);
        end
        check("single ovf", int'(bus.o_ovf), 0, 0);

        // Multi-channel: periods 20/30/50/70 ns, G=1000 -> 500/333/200/143.
        ring_half[0] = 10;
        run_window(1000, lat);
        check("multi latency", lat, 1002, 0);
        check("multi ovf", int'(bus.o_ovf), 0, 0);
        check("sat ovf", int'(sbus.o_ovf), 3, 0);
        foreach (mc_vec[i]) begin
            rd(mc_vec[i].ch, mc_vec[i].bsel, v, vs);
            check($sformatf("multi ch%0d b%0d", mc_vec[i].ch, mc_vec[i].bsel), v, mc_vec[i].exp, mc_vec[i].tol);
            check($sformatf("sat ch%0d b%0d", mc_vec[i].ch, mc_vec[i].bsel), vs, mc_vec[i].sexp, mc_vec[i].stol);
        end

        // Short window clears the sticky flag: 100 ns / 20 ns = 5, / 30 ns = 3.
        run_window(10, lat);
        check("g10 latency", lat, 12, 0);
        check("g10 sat ovf", int'(sbus.o_ovf), 0, 0);
        rd(0, 0, v, vs);
        check("g10 sat ch0", vs, 5, 1);
        rd(1, 0, v, vs);
        check("g10 sat ch1", vs, 3, 1);

        // Continuous: dones 52 apart, stray start ignored, stop after current window.
        ndone  = 0;
        off_at = -1;
        dt     = '{0, 0, 0, 0};
        bus.i_cont  = 1'b1;
        bus.i_gate  = GW'(50);
        bus.i_start = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1 || n == 81) bus.i_start = 1'b0;
            if (n == 80) bus.i_start = 1'b1;
            if (n == off_at) bus.i_cont = 1'b0;
            if (bus.o_done) begin
                if (ndone < 4) dt[ndone] = n;
                ndone++;
                if (ndone == 2) off_at = n + 10;
            end
        end
        check("cont done count", ndone, 3, 0);
        check("cont first", dt[0], 53, 0);
        check("cont period 1", dt[1] - dt[0], 52, 0);
        check("cont period 2", dt[2] - dt[1], 52, 0);
        check("cont idle after stop", int'(bus.o_busy), 0, 0);

        // Reset at cycle 30 of a G=100 window.
        bus.i_gate  = GW'(100);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (29) @(negedge clk);
        check("mid busy before rst", int'(bus.o_busy), 1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid busy after rst", int'(bus.o_busy), 0, 0);
        ndone = 0;
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            if (bus.o_done) ndone++;
        end
        check("mid no done", ndone, 0, 0);
        rd(0, 0, v, vs);
        check("mid result ch0", v, 0, 0);
        check("mid result8 ch0", vs, 0, 0);
        rd(1, 1, v, vs);
        check("mid result ch1 b1", v, 0, 0);

        // G=0 behaves as G=1.
        run_window(0, lat);
        check("g0 latency", lat, 3, 0);
        rd(0, 0, v, vs);
        check("g0 ch0", v, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
